// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring integer divider (div/divu/rem/remu) with
// valid/ready handshakes on request and result; one quotient bit per clock.
module seq_divider #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      opcode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] Y,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0]  q_reg;
  logic [XLEN-1:0]  rem_reg;
  logic [XLEN-1:0]  divisor_reg;
  logic             op_rem_reg;
  logic             op_signed_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;

  // Opcode decode: 100xy, x selects remainder, y selects unsigned.
  logic op_valid;
  logic op_is_rem;
  logic op_is_signed;
  assign op_valid     = (opcode[4:2] == 3'b100);
  assign op_is_rem    = opcode[1];
  assign op_is_signed = ~opcode[0];

  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  assign a_abs = (op_is_signed && A[XLEN-1]) ? -A : A;
  assign b_abs = (op_is_signed && B[XLEN-1]) ? -B : B;

  // Cases resolved without iterating: illegal opcode, divide by zero, signed overflow.
  logic            div_by_zero;
  logic            overflow;
  logic            take_fast;
  logic [XLEN-1:0] fast_y;
  assign div_by_zero = (B == '0);
  assign overflow    = op_is_signed && (A == MIN_NEG) && (B == '1);
  assign take_fast   = !op_valid || div_by_zero || overflow;

  always_comb begin
    fast_y = '0;
    if (!op_valid) begin
      fast_y = '0;
    end else if (div_by_zero) begin
      fast_y = op_is_rem ? A : '1;
    end else if (overflow) begin
      fast_y = op_is_rem ? '0 : A;
    end
  end

  // One restoring step; the shifted partial remainder needs one extra bit.
  logic [XLEN:0]   rem_shift;
  logic            rem_ge;
  logic [XLEN-1:0] step_rem;
  assign rem_shift = {rem_reg, q_reg[XLEN-1]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor_reg});
  assign step_rem  = rem_ge ? XLEN'(rem_shift - {1'b0, divisor_reg})
                            : rem_shift[XLEN-1:0];

  logic [XLEN-1:0] q_final;
  logic [XLEN-1:0] r_final;
  assign q_final = (op_signed_reg && sign_q_reg) ? -q_reg : q_reg;
  assign r_final = (op_signed_reg && sign_r_reg) ? -rem_reg : rem_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      q_reg         <= '0;
      rem_reg       <= '0;
      divisor_reg   <= '0;
      op_rem_reg    <= 1'b0;
      op_signed_reg <= 1'b0;
      sign_q_reg    <= 1'b0;
      sign_r_reg    <= 1'b0;
      Y             <= '0;
      out_valid     <= 1'b0;
      in_ready      <= 1'b1;
      busy          <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_rem_reg    <= op_is_rem;
            op_signed_reg <= op_is_signed;
            sign_q_reg    <= A[XLEN-1] ^ B[XLEN-1];
            sign_r_reg    <= A[XLEN-1];
            q_reg         <= a_abs;
            divisor_reg   <= b_abs;
            rem_reg       <= '0;
            cnt_reg       <= CNT_INIT;
            in_ready      <= 1'b0;
            busy          <= 1'b1;
            if (take_fast) begin
              Y         <= fast_y;
              out_valid <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          q_reg   <= {q_reg[XLEN-2:0], rem_ge};
          rem_reg <= step_rem;
          cnt_reg <= cnt_reg - CNT_ONE;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= FIX;
          end
        end
        FIX: begin
          Y         <= op_rem_reg ? r_final : q_final;
          out_valid <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          // Returning to IDLE first guarantees a gap cycle before the next accept.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector table, handshake/reset sequences and
// randomized operations checked against a plain-arithmetic reference model.
module tb_seq_divider;

  localparam int XLEN = 64;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_DIVU = 5'b10001;
  localparam logic [4:0] OP_REM  = 5'b10010;
  localparam logic [4:0] OP_REMU = 5'b10011;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int NORM_LAT = XLEN + 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_drv;
  logic [63:0] b_drv;
  logic [4:0]  op_drv;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] y_out;
  logic        busy;

  int n_vec;
  int n_err;

  seq_divider #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_drv),
    .B        (b_drv),
    .opcode   (op_drv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Y        (y_out),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [4:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] y;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] op, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] y, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.y = y; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Reference: language-level signed/unsigned / and %, with RISC-V M special cases.
  function automatic logic [63:0] model_y(input logic [4:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
    longint sa;
    longint sb;
    logic [63:0] r;
    sa = a;
    sb = b;
    r = '0;
    case (op)
      OP_DIV:  if (b == 0) r = ONES; else if (a == MIN && b == ONES) r = a; else r = 64'(sa / sb);
      OP_DIVU: if (b == 0) r = ONES; else r = a / b;
      OP_REM:  if (b == 0) r = a; else if (a == MIN && b == ONES) r = '0; else r = 64'(sa % sb);
      OP_REMU: if (b == 0) r = a; else r = a % b;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [63:0] a,
                                   input logic [63:0] b);
    if (op[4:2] != 3'b100) return 1;
    if (b == 0) return 1;
    if (!op[0] && a == MIN && b == ONES) return 1;
    return NORM_LAT;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_op(input string name, input logic [4:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp_y, input int exp_lat);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) check_int({name, " in_ready wait"}, 0, 1);
    op_drv = op; a_drv = a; b_drv = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_drv = {$urandom, $urandom};
    b_drv = {$urandom, $urandom};
    op_drv = 5'($urandom);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check64({name, " Y"}, y_out, exp_y);
    check_int({name, " latency"}, lat, exp_lat);
    $display("txn %s op=%b A=%h B=%h Y=%h exp=%h lat=%0d", name, op, a, b, y_out, exp_y, lat);
    if (out_ready) begin
      @(posedge clk); #1;
      check64({name, " handoff valid/ready/busy"}, {61'b0, out_valid, in_ready, busy}, 64'b010);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a_drv = '0;
    b_drv = '0;
    op_drv = '0;

    #3;
    check64("reset valid/ready/busy", {61'b0, out_valid, in_ready, busy}, 64'b010);
    check64("reset Y", y_out, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    add_vec(OP_DIVU, 64'd100, 64'd7, 64'd14, NORM_LAT);
    add_vec(OP_REM,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, NORM_LAT);
    add_vec(OP_DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, NORM_LAT);
    add_vec(OP_DIV,  64'h1234, 64'd0, ONES, 1);
    add_vec(OP_REM,  64'h1234, 64'd0, 64'h1234, 1);
    add_vec(OP_DIVU, 64'h1234, 64'd0, ONES, 1);
    add_vec(OP_REMU, 64'hFFFF_0000_1234_5678, 64'd0, 64'hFFFF_0000_1234_5678, 1);
    add_vec(OP_DIV,  MIN, ONES, MIN, 1);
    add_vec(OP_REM,  MIN, ONES, 64'd0, 1);
    add_vec(OP_DIVU, MIN, ONES, 64'd0, NORM_LAT);
    add_vec(OP_REMU, MIN, ONES, MIN, NORM_LAT);
    add_vec(OP_DIV,  MIN, 64'd2, 64'hC000_0000_0000_0000, NORM_LAT);
    add_vec(OP_DIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, NORM_LAT);
    add_vec(OP_REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, NORM_LAT);
    add_vec(OP_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, NORM_LAT);
    add_vec(OP_DIV,  64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 64'd14, NORM_LAT);
    add_vec(OP_REMU, ONES, 64'h10, 64'hF, NORM_LAT);
    add_vec(5'b00000, 64'd5, 64'd3, 64'd0, 1);
    add_vec(5'b10111, 64'd9, 64'd3, 64'd0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, vecs[i].lat);
    end

    // Consumer stall in DONE; a request presented meanwhile must not be taken early.
    out_ready = 1'b0;
    run_op("stall", OP_DIVU, 64'd1000, 64'd3, 64'd333, NORM_LAT);
    op_drv = OP_DIV; a_drv = 64'd50; b_drv = 64'd5; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check64("stall valid/ready", {62'b0, out_valid, in_ready}, 64'b10);
      check64("stall Y", y_out, 64'd333);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check64("stall release valid/ready/busy", {61'b0, out_valid, in_ready, busy}, 64'b010);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check64("post-stall accept ready/busy", {62'b0, in_ready, busy}, 64'b01);
    begin
      int guard;
      guard = 0;
      while (!out_valid && guard < 200) begin
        @(posedge clk); #1;
        guard++;
      end
      check_int("post-stall latency", guard + 1, NORM_LAT);
      check64("post-stall Y", y_out, 64'd10);
      $display("txn post-stall div 50/5 Y=%h", y_out);
      @(posedge clk); #1;
    end

    // Reset in the middle of CALC discards the operation.
    op_drv = OP_DIVU; a_drv = ONES; b_drv = 64'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1;
    check64("mid-calc busy/valid", {62'b0, busy, out_valid}, 64'b10);
    #1 rst = 1'b1;
    #1;
    check64("async reset valid/ready/busy", {61'b0, out_valid, in_ready, busy}, 64'b010);
    check64("async reset Y", y_out, 64'd0);
    $display("txn mid-calc reset applied");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check64("after reset no output", {63'b0, out_valid}, 64'd0);
    run_op("post-reset", OP_DIVU, ONES, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, NORM_LAT);

    for (int i = 0; i < 1000; i++) begin
      logic [4:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      int sel;
      sel = $urandom_range(0, 15);
      op = 5'b10000 | 5'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case (sel)
        0: b = '0;
        1: begin a = MIN; b = ONES; end
        2, 3, 4, 5: b = 64'($urandom_range(1, 300));
        6: a = 64'($urandom_range(0, 1000));
        7: b = {32'hFFFF_FFFF, 32'($urandom)};
        15: if ($urandom_range(0, 3) == 0) op = 5'($urandom);
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), op, a, b, model_y(op, a, b), model_lat(op, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
